// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared types and helpers for the iterative shifter.
//   op_e      : operation encoding carried on the 2-bit op port
//   state_e   : control FSM states (also exported on the debug port)
//   log2_ceil : elaboration-time log2, used to size SHAMT_W and step amounts
// -----------------------------------------------------------------------------
package shift_pkg;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_e;

   // Smallest n with 2**n >= v (v >= 2). SHAMT_W = log2_ceil(XLEN).
   function automatic int log2_ceil(input int v);
      int n;
      n = 0;
      while ((1 << n) < v) n++;
      return n;
   endfunction

endpackage

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Combinational shift of data_in by 0..STEP positions.
//   data_in  : value to shift (XLEN)
//   amt      : positions to shift this cycle, 0..STEP
//   op       : SLL / SRL zero-fill, SRA sign-fill, reserved passes through
//   data_out : shifted value (XLEN)
// -----------------------------------------------------------------------------
module shift_step
   import shift_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int STEP  = 4,
   parameter int AMT_W = log2_ceil(STEP + 1)
)(
   input  logic [XLEN-1:0]  data_in,
   input  logic [AMT_W-1:0] amt,
   input  op_e              op,
   output logic [XLEN-1:0]  data_out
);

   always_comb begin
      data_out = data_in;
      case (op)
         OP_SLL:  data_out = data_in << amt;
         OP_SRL:  data_out = data_in >> amt;
         OP_SRA:  data_out = XLEN'($signed(data_in) >>> amt);
         default: data_out = data_in;
      endcase
   end

endmodule

// File: rtl/iterative_shifter.sv
// -----------------------------------------------------------------------------
// iterative_shifter
// Multi-cycle barrel-less shifter: shifts at most STEP positions per cycle.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   flush        : synchronous abort; forces IDLE at the next edge
//   in_valid/in_ready   : request handshake (op, word, operand, shamt_raw)
//   out_valid/out_ready : result handshake (result)
//   busy         : FSM is not in IDLE
//   state_dbg    : current FSM state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE; out_valid is 1 only in DONE, and the
// result is held unchanged until out_ready is seen. The DONE->IDLE edge never
// accepts a new request, and flush suppresses any accept on its edge.
// -----------------------------------------------------------------------------
module iterative_shifter
   import shift_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] operand,
   input  logic [XLEN-1:0] shamt_raw,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy,
   output state_e          state_dbg
);

   localparam int SHAMT_W = log2_ceil(XLEN);
   localparam int AMT_W   = log2_ceil(STEP + 1);

   state_e              state;
   op_e                 op_q;
   logic                word_q;
   logic [XLEN-1:0]     acc;
   logic [SHAMT_W-1:0]  remaining;

   logic                word_mode_in;
   logic [SHAMT_W-1:0]  shamt_in;
   logic [XLEN-1:0]     preload;
   logic [AMT_W-1:0]    step_amt;
   logic [SHAMT_W-1:0]  rem_next;
   logic [XLEN-1:0]     step_out;

   // Upper shamt bits are masked away by design; word is a no-op at XLEN=32.
   logic unused_bits;
   assign unused_bits = ^{shamt_raw, word};

   // Word mode only exists on a 64-bit datapath.
   assign word_mode_in = (XLEN == 64) && word;

   // Final word-mode result is the low 32 bits sign-extended from bit 31.
   function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] v,
                                                input logic            wm);
      logic [XLEN-1:0] r;
      r = v;
      if (wm)
         for (int i = 32; i < XLEN; i++) r[i] = v[31];
      return r;
   endfunction

   always_comb begin
      shamt_in = shamt_raw[SHAMT_W-1:0];
      if (word_mode_in) shamt_in = SHAMT_W'(shamt_raw[4:0]);
      if (op_e'(op) == OP_RSVD) shamt_in = '0;

      // In word mode the upper half is preloaded so that a full-width shift
      // produces the right low 32 bits: zeros for SRL, sign copies for SRA.
      preload = operand;
      if (word_mode_in)
         for (int i = 32; i < XLEN; i++)
            preload[i] = (op_e'(op) == OP_SRA) ? operand[31] : 1'b0;
   end

   // min(STEP, remaining); widened compare because STEP may equal XLEN.
   always_comb begin
      if ({1'b0, remaining} >= (SHAMT_W + 1)'(STEP))
         step_amt = AMT_W'(STEP);
      else
         step_amt = AMT_W'(remaining);
      rem_next = remaining - SHAMT_W'(step_amt);
   end

   shift_step #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_step (
      .data_in  (acc),
      .amt      (step_amt),
      .op       (op_q),
      .data_out (step_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= OP_SLL;
         word_q    <= 1'b0;
         acc       <= '0;
         remaining <= '0;
         result    <= '0;
      end else if (flush) begin
         state     <= S_IDLE;
         remaining <= '0;
         result    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q      <= op_e'(op);
                  word_q    <= word_mode_in;
                  acc       <= preload;
                  remaining <= shamt_in;
                  if (shamt_in == '0) begin
                     state  <= S_DONE;
                     result <= finalize(preload, word_mode_in);
                  end else begin
                     state  <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               acc       <= step_out;
               remaining <= rem_next;
               if (rem_next == '0) begin
                  state  <= S_DONE;
                  result <= finalize(step_out, word_q);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state  <= S_IDLE;
                  result <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;

endmodule

// File: tb/tb_iterative_shifter.sv
// -----------------------------------------------------------------------------
// tb_iterative_shifter
// Two instances share the request bus: dut32 (XLEN=32, STEP=4) and
// dut64 (XLEN=64, STEP=4); each has its own in_valid. Directed vector table
// plus hand-written sequences for hold, flush and reset corner cases.
// -----------------------------------------------------------------------------
module tb_iterative_shifter;
   import shift_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        flush = 1'b0;
   logic        in_valid32 = 1'b0;
   logic        in_valid64 = 1'b0;
   logic [1:0]  op_s = 2'b00;
   logic        word_s = 1'b0;
   logic [63:0] operand_s = '0;
   logic [63:0] shamt_s = '0;
   logic        out_ready = 1'b0;

   logic        in_ready32, out_valid32, busy32;
   logic [31:0] result32;
   state_e      state32;
   logic        in_ready64, out_valid64, busy64;
   logic [63:0] result64;
   state_e      state64;

   iterative_shifter #(.XLEN(32), .STEP(4)) dut32 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid32),
      .in_ready  (in_ready32),
      .op        (op_s),
      .word      (word_s),
      .operand   (operand_s[31:0]),
      .shamt_raw (shamt_s[31:0]),
      .out_valid (out_valid32),
      .out_ready (out_ready),
      .result    (result32),
      .busy      (busy32),
      .state_dbg (state32)
   );

   iterative_shifter #(.XLEN(64), .STEP(4)) dut64 (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid64),
      .in_ready  (in_ready64),
      .op        (op_s),
      .word      (word_s),
      .operand   (operand_s),
      .shamt_raw (shamt_s),
      .out_valid (out_valid64),
      .out_ready (out_ready),
      .result    (result64),
      .busy      (busy64),
      .state_dbg (state64)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      string       name;
      bit          sel64;
      logic [1:0]  op;
      bit          word;
      logic [63:0] operand;
      logic [63:0] shamt;
      logic [63:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic launch(input bit sel64, input logic [1:0] op, input bit word,
                         input logic [63:0] operand, input logic [63:0] shamt);
      @(negedge clk);
      op_s      = op;
      word_s    = word;
      operand_s = operand;
      shamt_s   = shamt;
      if (sel64) in_valid64 = 1'b1;
      else       in_valid32 = 1'b1;
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
   endtask

   // Counts cycles from the accept edge until out_valid is seen; -1 on timeout.
   task automatic wait_valid(input bit sel64, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      while (!seen && lat < 60) begin
         @(negedge clk);
         lat++;
         seen = sel64 ? out_valid64 : out_valid32;
      end
      if (!seen) lat = -1;
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int          lat;
      logic [63:0] res;
      logic [63:0] exp;
      exp_q.push_back(v.exp_res);
      launch(v.sel64, v.op, v.word, v.operand, v.shamt);
      wait_valid(v.sel64, lat);
      res = v.sel64 ? result64 : {32'h0, result32};
      exp = exp_q.pop_front();
      check({v.name, "_result"}, res, exp);
      check({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
      if (lat > 0) consume();
   endtask

   task automatic watch_no_valid(input bit sel64, input int n, input string name);
      int pulses;
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (sel64 ? out_valid64 : out_valid32) pulses++;
      end
      check(name, 64'(pulses), 64'd0);
   endtask

   // ---------------- test ----------------
   initial begin
      int lat;

      vecs[0]  = '{"sll_mask25",   1'b0, 2'b00, 1'b0, 64'h0000_0001, 64'h25, 64'h0000_0020, 3};
      vecs[1]  = '{"sra_31",       1'b0, 2'b10, 1'b0, 64'h8000_0000, 64'd31, 64'hFFFF_FFFF, 9};
      vecs[2]  = '{"srl_31",       1'b0, 2'b01, 1'b0, 64'h8000_0000, 64'd31, 64'h0000_0001, 9};
      vecs[3]  = '{"rsvd_op",      1'b0, 2'b11, 1'b0, 64'h1234_5678, 64'd7,  64'h1234_5678, 1};
      vecs[4]  = '{"sll_zero",     1'b0, 2'b00, 1'b0, 64'h1234_5678, 64'd0,  64'h1234_5678, 1};
      vecs[5]  = '{"sra_pos16",    1'b0, 2'b10, 1'b0, 64'h7FFF_0000, 64'd16, 64'h0000_7FFF, 5};
      vecs[6]  = '{"sll_4",        1'b0, 2'b00, 1'b0, 64'hFFFF_FFFF, 64'd4,  64'hFFFF_FFF0, 2};
      vecs[7]  = '{"sra_mask21",   1'b0, 2'b10, 1'b0, 64'hF000_0000, 64'h21, 64'hF800_0000, 2};
      vecs[8]  = '{"w_srl_4",      1'b1, 2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4,  64'h0000_0000_0800_0000, 2};
      vecs[9]  = '{"w_sra_4",      1'b1, 2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4,  64'hFFFF_FFFF_F800_0000, 2};
      vecs[10] = '{"w_sll_1",      1'b1, 2'b00, 1'b1, 64'h0000_0000_4000_0000, 64'd1,  64'hFFFF_FFFF_8000_0000, 2};
      vecs[11] = '{"w_srl_mask3f", 1'b1, 2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h3F, 64'h0000_0000_0000_0001, 9};
      vecs[12] = '{"d_sra_63",     1'b1, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 17};
      vecs[13] = '{"d_sll_mask40", 1'b1, 2'b00, 1'b0, 64'h0000_0000_0000_0001, 64'h40, 64'h0000_0000_0000_0001, 1};
      vecs[14] = '{"d_srl_60",     1'b1, 2'b01, 1'b0, 64'hF000_0000_0000_0000, 64'd60, 64'h0000_0000_0000_000F, 16};
      vecs[15] = '{"w_srl_zero",   1'b1, 2'b01, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1};

      // Reset state, sampled while rst_n is still low.
      repeat (2) @(negedge clk);
      check("rst_out_valid32", {63'h0, out_valid32}, 64'd0);
      check("rst_result32",    {32'h0, result32},    64'd0);
      check("rst_busy32",      {63'h0, busy32},      64'd0);
      check("rst_result64",    result64,             64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready32",  {63'h0, in_ready32},  64'd1);
      check("rst_in_ready64",  {63'h0, in_ready64},  64'd1);
      check("rst_state32",     {62'h0, state32},     {62'h0, S_IDLE});

      // Table-driven vectors.
      for (int i = 0; i < 16; i++) run_vec(vecs[i]);

      // Result held in DONE while out_ready stays low.
      launch(1'b0, 2'b01, 1'b0, 64'h0000_00F0, 64'd4);
      wait_valid(1'b0, lat);
      check("hold_latency", 64'(lat), 64'd2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_result",    {32'h0, result32},   64'h0000_000F);
         check("hold_in_ready",  {63'h0, in_ready32}, 64'd0);
         check("hold_out_valid", {63'h0, out_valid32}, 64'd1);
      end
      // Request offered on the release edge must not be taken.
      @(negedge clk);
      out_ready  = 1'b1;
      in_valid32 = 1'b1;
      op_s       = 2'b00;
      shamt_s    = 64'd8;
      @(posedge clk);
      #1;
      out_ready  = 1'b0;
      in_valid32 = 1'b0;
      check("release_busy",      {63'h0, busy32},      64'd0);
      check("release_in_ready",  {63'h0, in_ready32},  64'd1);
      check("release_out_valid", {63'h0, out_valid32}, 64'd0);
      check("release_result",    {32'h0, result32},    64'd0);
      watch_no_valid(1'b0, 4, "release_no_accept");

      // Flush during SHIFT, with a simultaneous request that must lose.
      launch(1'b0, 2'b10, 1'b0, 64'h8000_0000, 64'd31);
      repeat (3) @(negedge clk);
      check("pre_flush_busy", {63'h0, busy32}, 64'd1);
      flush      = 1'b1;
      in_valid32 = 1'b1;
      shamt_s    = 64'd3;
      @(posedge clk);
      #1;
      flush      = 1'b0;
      in_valid32 = 1'b0;
      check("flush_state", {62'h0, state32}, {62'h0, S_IDLE});
      check("flush_busy",  {63'h0, busy32},  64'd0);
      watch_no_valid(1'b0, 12, "flush_no_valid");
      run_vec(vecs[0]);

      // Asynchronous reset during SHIFT.
      launch(1'b1, 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'd63);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_shift_busy",   {63'h0, busy64},      64'd0);
      check("rst_shift_state",  {62'h0, state64},     {62'h0, S_IDLE});
      check("rst_shift_result", result64,             64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_shift_in_ready", {63'h0, in_ready64}, 64'd1);
      watch_no_valid(1'b1, 20, "rst_shift_no_valid");
      run_vec(vecs[9]);

      // Asynchronous reset while in DONE.
      launch(1'b0, 2'b00, 1'b0, 64'h0000_0055, 64'd0);
      @(negedge clk);
      check("pre_rst_done_valid", {63'h0, out_valid32}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_done_valid",  {63'h0, out_valid32}, 64'd0);
      check("rst_done_result", {32'h0, result32},    64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_valid(1'b0, 5, "rst_done_no_valid");
      run_vec(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $finish;
   end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 The block SHALL have parameter STEP, default 4, maximum bit positions shifted per cycle; power of two, 1..XLEN.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-006 The block SHALL have port in_valid  input  1  request present.
REQ-007 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-008 The block SHALL have port op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-009 The block SHALL have port word  input  1  32-bit (W) variant; ignored when XLEN=32.
REQ-010 The block SHALL have port operand  input  XLEN  value to shift.
REQ-011 The block SHALL have port shamt_raw  input  XLEN  unmasked shift amount (register or immediate).
REQ-012 The block SHALL have port out_valid  output  1  result present.
REQ-013 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-014 The block SHALL have port result  output  XLEN  shifted value.
REQ-015 The block SHALL have port busy  output  1  state is not IDLE.

Function
REQ-016 The block SHALL implement states IDLE, SHIFT and DONE; in_ready SHALL be 1 only in IDLE, out_valid 1 only in DONE.
REQ-017 On an accept (in_valid and in_ready and not flush), the block SHALL register operand, op and word, and set remaining = shamt_raw masked to log2(XLEN) bits, or to 5 bits when word=1 and XLEN=64.
REQ-018 Op 11 SHALL be treated as shamt 0 and return the operand unchanged.
REQ-019 After an accept, the next state SHALL be DONE if remaining=0, else SHIFT.
REQ-020 Each SHIFT cycle SHALL shift by min(STEP, remaining) and decrement remaining by that amount, moving to DONE when remaining reaches 0.
REQ-021 Latency from the accept edge to out_valid SHALL be exactly 1 + ceil(remaining/STEP) cycles.
REQ-022 SLL SHALL zero-fill, SRL SHALL zero-fill from the MSB, and SRA SHALL replicate the sign bit.
REQ-023 In word mode, the preload above bit 31 SHALL be zeros for SRL and copies of operand[31] for SRA, and the final result SHALL be the low 32 bits sign-extended from bit 31.
REQ-024 In DONE, result SHALL be held stable until out_ready=1, and the block SHALL then return to IDLE; no accept is possible in that same cycle.
REQ-025 Flush SHALL force IDLE at the next edge from any state, discard the in-flight result, and win over a simultaneous in_valid.
REQ-026 result SHALL be registered, and SHALL be 0 whenever out_valid=0.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, remaining=0, result=0, out_valid=0 and busy=0, with in_ready=1 once rst_n is high.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL drop the operation with no out_valid pulse afterwards.

Structure
REQ-029 Package shift_pkg SHALL hold the op encoding enum, the state enum and the localparam SHAMT_W = log2(XLEN) helper function.
REQ-030 One sub-module, shift_step, SHALL be used: a combinational shift by 0..STEP positions with op-dependent fill, instantiated once.

Verification
REQ-031 A bench SHALL drive XLEN=32, STEP=4, SLL, operand 0x0000_0001, shamt_raw 0x25 (masked to 5), and require result 0x0000_0020 with out_valid 3 cycles after accept.
REQ-032 A bench SHALL drive SRA, operand 0x8000_0000, shamt_raw 31, STEP=4, and require result 0xFFFF_FFFF after 1+8 cycles.
REQ-033 A bench SHALL drive XLEN=64, word=1, SRL, operand 0xFFFF_FFFF_8000_0000, shamt 4, and require result 0x0000_0000_0800_0000.
REQ-034 A bench SHALL drive shamt 0 and op 11 with operand 0x1234_5678, and require out_valid 1 cycle after accept with result equal to the operand.
REQ-035 A bench SHALL hold out_ready=0 for 5 cycles in DONE and require result stable and in_ready=0; one cycle of out_ready then returns the block to IDLE.
REQ-036 A bench SHALL assert flush and, separately, rst_n=0 during SHIFT, and require IDLE, no out_valid pulse, and that the next request completes correctly.
